// File: rtl/gp_time_base.sv
// gp_time_base: general-purpose timer time base.
// Prescaler, auto-reload counter (edge-aligned up/down or center-aligned),
// ARR/PSC shadow registers, update event/flag generation, one-pulse mode
// and slave gate/trigger/reset inputs.
// Optional feature macro: GP_TIME_BASE_RCR_EN adds the repetition counter.
// When it is undefined rcr_i is ignored and every over/underflow qualifies.
module gp_time_base #(
    parameter int CNT_WIDTH = 32,
    parameter int PSC_WIDTH = 16,
    parameter int RCR_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cen_i,
    input  logic                 gate_cnt_i,
    input  logic                 trig_cnt_i,
    input  logic                 rst_cnt_i,
    input  logic                 ug_i,
    input  logic [CNT_WIDTH-1:0] arr_i,
    input  logic [PSC_WIDTH-1:0] psc_i,
    input  logic [RCR_WIDTH-1:0] rcr_i,
    input  logic                 dir_i,
    input  logic [1:0]           cms_i,
    input  logic                 apre_i,
    input  logic                 opm_i,
    input  logic                 udis_i,
    input  logic                 urs_i,
    input  logic                 uif_clr_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 dir_o,
    output logic                 uev_o,
    output logic                 uif_o,
    output logic                 run_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [PSC_WIDTH-1:0] PSC_ONE = PSC_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] arr_shadow_q, arr_shadow_d;
    logic [CNT_WIDTH-1:0] arr_use;
    logic [PSC_WIDTH-1:0] psc_cnt_q, psc_cnt_d;
    logic [PSC_WIDTH-1:0] psc_shadow_q, psc_shadow_d;
    logic                 dir_q, dir_d;
    logic                 uev_q, uev_d;
    logic                 uif_q, uif_d;
    logic                 run_q, run_d;
    logic                 cen_q;

    logic sw_ug;     // software / slave-reset update request
    logic en;        // counter clock enable
    logic tick;      // prescaler output
    logic center;    // center-aligned mode
    logic evt;       // over/underflow on a tick that was not overridden
    logic rep_ok;    // repetition condition satisfied
    logic cnt_uev;   // qualified counter update event
    logic any_uev;   // counter or software update event

    assign sw_ug   = ug_i | rst_cnt_i;
    assign en      = run_q & gate_cnt_i;
    assign tick    = en & (psc_cnt_q == psc_shadow_q);
    assign center  = (cms_i != 2'b00);
    assign arr_use = apre_i ? arr_shadow_q : arr_i;
    assign cnt_uev = evt & rep_ok & ~udis_i;
    assign any_uev = cnt_uev | sw_ug;

    // Counter and direction next state; a software update overrides any tick.
    always_comb begin
        cnt_d = cnt_q;
        dir_d = center ? dir_q : dir_i;
        evt   = 1'b0;
        if (sw_ug) begin
            // Edge-down restarts from the ARR value the shadow takes this edge.
            cnt_d = (!center && dir_i) ? arr_i : '0;
            if (center) begin
                dir_d = 1'b0;
            end
        end else if (tick) begin
            if (!center) begin
                if (!dir_i) begin
                    if (cnt_q == arr_use) begin
                        cnt_d = '0;
                        evt   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    if (cnt_q == '0) begin
                        cnt_d = arr_use;
                        evt   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end else if (arr_use == '0) begin
                cnt_d = '0;
                dir_d = 1'b0;
                evt   = 1'b1;
            end else if (!dir_q) begin
                if (cnt_q == arr_use) begin
                    cnt_d = arr_use - CNT_ONE;
                    dir_d = 1'b1;
                    evt   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end else begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_ONE;
                    dir_d = 1'b0;
                    evt   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
        end
    end

`ifdef GP_TIME_BASE_RCR_EN
    localparam logic [RCR_WIDTH-1:0] REP_ONE = RCR_WIDTH'(1);

    logic [RCR_WIDTH-1:0] rep_cnt_q, rep_cnt_d;

    // Repetition counter: only the event that finds it at zero qualifies.
    always_comb begin
        rep_cnt_d = rep_cnt_q;
        rep_ok    = 1'b0;
        if (sw_ug) begin
            rep_cnt_d = rcr_i;
        end else if (evt) begin
            if (rep_cnt_q == '0) begin
                rep_ok    = 1'b1;
                rep_cnt_d = rcr_i;
            end else begin
                rep_cnt_d = rep_cnt_q - REP_ONE;
            end
        end
    end

    // Repetition counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
        end
    end
`else
    logic unused_rcr;

    assign rep_ok     = 1'b1;
    assign unused_rcr = ^rcr_i;
`endif

    // Prescaler, shadows, flags and run control next state.
    always_comb begin
        psc_cnt_d    = psc_cnt_q;
        arr_shadow_d = arr_shadow_q;
        psc_shadow_d = psc_shadow_q;
        uev_d        = any_uev;
        uif_d        = uif_q;
        run_d        = run_q;

        if (sw_ug) begin
            psc_cnt_d = '0;
        end else if (en) begin
            psc_cnt_d = tick ? '0 : (psc_cnt_q + PSC_ONE);
        end

        if (any_uev) begin
            arr_shadow_d = arr_i;
            psc_shadow_d = psc_i;
        end

        // Set has priority over a coincident clear.
        if (cnt_uev || (sw_ug && !urs_i)) begin
            uif_d = 1'b1;
        end else if (uif_clr_i) begin
            uif_d = 1'b0;
        end

        if (!cen_i) begin
            run_d = 1'b0;
        end else if (cnt_uev && opm_i) begin
            run_d = 1'b0;
        end else if (!cen_q || trig_cnt_i) begin
            run_d = 1'b1;
        end
    end

    // State registers; cen_q resets low so a held enable reads as a rising edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            psc_cnt_q    <= '0;
            arr_shadow_q <= '0;
            psc_shadow_q <= '0;
            dir_q        <= 1'b0;
            uev_q        <= 1'b0;
            uif_q        <= 1'b0;
            run_q        <= 1'b0;
            cen_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            psc_cnt_q    <= psc_cnt_d;
            arr_shadow_q <= arr_shadow_d;
            psc_shadow_q <= psc_shadow_d;
            dir_q        <= dir_d;
            uev_q        <= uev_d;
            uif_q        <= uif_d;
            run_q        <= run_d;
            cen_q        <= cen_i;
        end
    end

    assign cnt_o = cnt_q;
    assign dir_o = dir_q;
    assign uev_o = uev_q;
    assign uif_o = uif_q;
    assign run_o = run_q;

endmodule

// File: tb/tb_gp_time_base.sv
// Bench for gp_time_base: a per-cycle vector table plus hand-written
// sequences for preload, update priority, one-pulse and mid-count reset.
module tb_gp_time_base;

    logic       clk_i = 1'b0;
    logic       rst_i, cen_i, gate_cnt_i, trig_cnt_i, rst_cnt_i, ug_i;
    logic [7:0] arr_i;
    logic [3:0] psc_i;
    logic [3:0] rcr_i;
    logic       dir_i;
    logic [1:0] cms_i;
    logic       apre_i, opm_i, udis_i, urs_i, uif_clr_i;
    logic [7:0] cnt_o;
    logic       dir_o, uev_o, uif_o, run_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected {uev, cnt} values for the preload sequence.
    logic [8:0] exp_q[$];

    typedef struct {
        logic       cen, gate, ug, clr;
        logic [1:0] cms;
        logic       dir;
        logic [7:0] arr;
        logic [3:0] psc;
        logic [7:0] e_cnt;
        logic       e_dir, e_uev, e_uif, e_run;
    } vec_t;

    vec_t tbl[34];

    gp_time_base #(.CNT_WIDTH(8), .PSC_WIDTH(4), .RCR_WIDTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cen_i(cen_i), .gate_cnt_i(gate_cnt_i),
        .trig_cnt_i(trig_cnt_i), .rst_cnt_i(rst_cnt_i), .ug_i(ug_i),
        .arr_i(arr_i), .psc_i(psc_i), .rcr_i(rcr_i), .dir_i(dir_i),
        .cms_i(cms_i), .apre_i(apre_i), .opm_i(opm_i), .udis_i(udis_i),
        .urs_i(urs_i), .uif_clr_i(uif_clr_i), .cnt_o(cnt_o), .dir_o(dir_o),
        .uev_o(uev_o), .uif_o(uif_o), .run_o(run_o)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(int cen, int gate, int ug, int clr, int cms, int dir,
                                int arr, int psc, int e_cnt, int e_dir, int e_uev,
                                int e_uif, int e_run);
        vec_t v;
        v.cen = 1'(cen);  v.gate = 1'(gate); v.ug = 1'(ug); v.clr = 1'(clr);
        v.cms = 2'(cms);  v.dir = 1'(dir);   v.arr = 8'(arr); v.psc = 4'(psc);
        v.e_cnt = 8'(e_cnt); v.e_dir = 1'(e_dir); v.e_uev = 1'(e_uev);
        v.e_uif = 1'(e_uif); v.e_run = 1'(e_run);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e_cnt, input int e_dir,
                           input int e_uev, input int e_uif, input int e_run);
        chk({tag, " cnt"}, 32'(cnt_o), 32'(e_cnt));
        chk({tag, " dir"}, 32'(dir_o), 32'(e_dir));
        chk({tag, " uev"}, 32'(uev_o), 32'(e_uev));
        chk({tag, " uif"}, 32'(uif_o), 32'(e_uif));
        chk({tag, " run"}, 32'(run_o), 32'(e_run));
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Vector table: inputs applied before an edge, outputs expected after it.
        //              cen gt ug cl cms dr arr psc | cnt dir uev uif run
        tbl[0]  = mk(1, 1, 0, 0, 0, 0, 3, 1,   0, 0, 0, 0, 1);
        tbl[1]  = mk(1, 1, 0, 0, 0, 0, 3, 1,   1, 0, 0, 0, 1);
        tbl[2]  = mk(1, 1, 0, 0, 0, 0, 3, 1,   2, 0, 0, 0, 1);
        tbl[3]  = mk(0, 1, 0, 0, 0, 0, 3, 1,   3, 0, 0, 0, 0);
        tbl[4]  = mk(0, 1, 0, 0, 0, 0, 3, 1,   3, 0, 0, 0, 0);
        tbl[5]  = mk(1, 1, 0, 0, 0, 0, 3, 1,   3, 0, 0, 0, 1);
        tbl[6]  = mk(1, 1, 0, 0, 0, 0, 3, 1,   0, 0, 1, 1, 1);
        tbl[7]  = mk(1, 1, 0, 0, 0, 0, 3, 1,   0, 0, 0, 1, 1);
        tbl[8]  = mk(0, 1, 1, 1, 0, 0, 3, 1,   0, 0, 1, 0, 0);
        tbl[9]  = mk(1, 1, 0, 0, 0, 0, 3, 1,   0, 0, 0, 0, 1);
        tbl[10] = mk(1, 1, 0, 0, 0, 0, 3, 1,   0, 0, 0, 0, 1);
        tbl[11] = mk(1, 1, 0, 0, 0, 0, 3, 1,   1, 0, 0, 0, 1);
        tbl[12] = mk(1, 1, 0, 0, 0, 0, 3, 1,   1, 0, 0, 0, 1);
        tbl[13] = mk(1, 1, 0, 0, 0, 0, 3, 1,   2, 0, 0, 0, 1);
        tbl[14] = mk(1, 1, 0, 0, 0, 0, 3, 1,   2, 0, 0, 0, 1);
        tbl[15] = mk(1, 1, 0, 0, 0, 0, 3, 1,   3, 0, 0, 0, 1);
        tbl[16] = mk(1, 1, 0, 0, 0, 0, 3, 1,   3, 0, 0, 0, 1);
        tbl[17] = mk(1, 1, 0, 0, 0, 0, 3, 1,   0, 0, 1, 1, 1);
        tbl[18] = mk(1, 1, 1, 0, 1, 0, 2, 0,   0, 0, 1, 1, 1);
        tbl[19] = mk(1, 1, 0, 0, 1, 0, 2, 0,   1, 0, 0, 1, 1);
        tbl[20] = mk(1, 1, 0, 0, 1, 0, 2, 0,   2, 0, 0, 1, 1);
        tbl[21] = mk(1, 1, 0, 0, 1, 0, 2, 0,   1, 1, 1, 1, 1);
        tbl[22] = mk(1, 1, 0, 0, 1, 0, 2, 0,   0, 1, 0, 1, 1);
        tbl[23] = mk(1, 1, 0, 0, 1, 0, 2, 0,   1, 0, 1, 1, 1);
        tbl[24] = mk(1, 1, 0, 0, 1, 0, 2, 0,   2, 0, 0, 1, 1);
        tbl[25] = mk(1, 1, 0, 0, 0, 1, 2, 0,   1, 1, 0, 1, 1);
        tbl[26] = mk(1, 1, 0, 0, 0, 1, 2, 0,   0, 1, 0, 1, 1);
        tbl[27] = mk(1, 1, 0, 0, 0, 1, 2, 0,   2, 1, 1, 1, 1);
        tbl[28] = mk(1, 1, 0, 0, 0, 1, 2, 0,   1, 1, 0, 1, 1);
        tbl[29] = mk(1, 1, 0, 0, 2, 1, 0, 0,   0, 0, 1, 1, 1);
        tbl[30] = mk(1, 1, 0, 0, 2, 1, 0, 0,   0, 0, 1, 1, 1);
        tbl[31] = mk(1, 0, 0, 0, 0, 0, 3, 0,   0, 0, 0, 1, 1);
        tbl[32] = mk(1, 1, 0, 0, 0, 0, 3, 0,   1, 0, 0, 1, 1);
        tbl[33] = mk(1, 1, 0, 1, 0, 0, 3, 0,   2, 0, 0, 0, 1);

        // Reset with cen_i already high
        rst_i = 1'b1; cen_i = 1'b1; gate_cnt_i = 1'b1; trig_cnt_i = 1'b0;
        rst_cnt_i = 1'b0; ug_i = 1'b0; arr_i = 8'd3; psc_i = 4'd1; rcr_i = 4'd0;
        dir_i = 1'b0; cms_i = 2'b00; apre_i = 1'b0; opm_i = 1'b0; udis_i = 1'b0;
        urs_i = 1'b1; uif_clr_i = 1'b0;
        step();
        step();
        chk_all("reset", 0, 0, 0, 0, 0);
        rst_i = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 34; i++) begin
            cen_i = tbl[i].cen; gate_cnt_i = tbl[i].gate; ug_i = tbl[i].ug;
            uif_clr_i = tbl[i].clr; cms_i = tbl[i].cms; dir_i = tbl[i].dir;
            arr_i = tbl[i].arr; psc_i = tbl[i].psc;
            step();
            chk_all($sformatf("vec%0d", i), int'(tbl[i].e_cnt), int'(tbl[i].e_dir),
                    int'(tbl[i].e_uev), int'(tbl[i].e_uif), int'(tbl[i].e_run));
        end
        ug_i = 1'b0; uif_clr_i = 1'b0; gate_cnt_i = 1'b1; cen_i = 1'b1;

        // ARR preload: a new arr_i mid-period takes effect only after the wrap
        apre_i = 1'b1; arr_i = 8'd5; psc_i = 4'd0; cms_i = 2'b00; dir_i = 1'b0;
        ug_i = 1'b1;
        step();
        chk("pre ug cnt", 32'(cnt_o), 32'd0);
        chk("pre ug uev", 32'(uev_o), 32'd1);
        ug_i = 1'b0;
        exp_q.push_back({1'b0, 8'd1});
        exp_q.push_back({1'b0, 8'd2});
        exp_q.push_back({1'b0, 8'd3});
        exp_q.push_back({1'b0, 8'd4});
        exp_q.push_back({1'b0, 8'd5});
        exp_q.push_back({1'b1, 8'd0});
        exp_q.push_back({1'b0, 8'd1});
        exp_q.push_back({1'b0, 8'd2});
        exp_q.push_back({1'b1, 8'd0});
        for (int k = 0; k < 9; k++) begin
            logic [8:0] e;
            step();
            e = exp_q.pop_front();
            chk($sformatf("pre%0d cnt", k), 32'(cnt_o), 32'(e[7:0]));
            chk($sformatf("pre%0d uev", k), 32'(uev_o), 32'(e[8]));
            if (k == 2) arr_i = 8'd2;
        end
        chk("pre uif", 32'(uif_o), 32'd1);
        apre_i = 1'b0;

        // ug_i coincident with an overflow tick, urs_i=1; then udis_i behaviour
        uif_clr_i = 1'b1;
        step();
        chk("ugov clr cnt", 32'(cnt_o), 32'd1);
        chk("ugov clr uif", 32'(uif_o), 32'd0);
        uif_clr_i = 1'b0;
        step();
        chk("ugov cnt2", 32'(cnt_o), 32'd2);
        ug_i = 1'b1;
        step();
        ug_i = 1'b0;
        chk("ugov cnt", 32'(cnt_o), 32'd0);
        chk("ugov uev", 32'(uev_o), 32'd1);
        chk("ugov uif", 32'(uif_o), 32'd0);
        step();
        chk("ugov next cnt", 32'(cnt_o), 32'd1);
        chk("ugov next uev", 32'(uev_o), 32'd0);
        step();
        udis_i = 1'b1;
        step();
        chk("udis wrap cnt", 32'(cnt_o), 32'd0);
        chk("udis wrap uev", 32'(uev_o), 32'd0);
        chk("udis wrap uif", 32'(uif_o), 32'd0);
        step();
        urs_i = 1'b0; ug_i = 1'b1;
        step();
        chk("udis ug uev", 32'(uev_o), 32'd1);
        chk("udis ug uif", 32'(uif_o), 32'd1);
        chk("udis ug cnt", 32'(cnt_o), 32'd0);
        ug_i = 1'b0; udis_i = 1'b0; urs_i = 1'b1;

        // One-pulse mode
        opm_i = 1'b1; arr_i = 8'd1; psc_i = 4'd0; rcr_i = 4'd2;
        ug_i = 1'b1; uif_clr_i = 1'b1;
        step();
        chk_all("opm ug", 0, 0, 1, 0, 1);
        ug_i = 1'b0; uif_clr_i = 1'b0;
`ifdef GP_TIME_BASE_RCR_EN
        step(); chk_all("opm c1", 1, 0, 0, 0, 1);
        step(); chk_all("opm c2", 0, 0, 0, 0, 1);
        step(); chk_all("opm c3", 1, 0, 0, 0, 1);
        step(); chk_all("opm c4", 0, 0, 0, 0, 1);
        step(); chk_all("opm c5", 1, 0, 0, 0, 1);
        step(); chk_all("opm c6", 0, 0, 1, 1, 0);
        step(); chk_all("opm c7", 0, 0, 0, 1, 0);
`else
        step(); chk_all("opm c1", 1, 0, 0, 0, 1);
        step(); chk_all("opm c2", 0, 0, 1, 1, 0);
        step(); chk_all("opm c3", 0, 0, 0, 1, 0);
`endif
        trig_cnt_i = 1'b1;
        step();
        trig_cnt_i = 1'b0;
        chk_all("opm trig", 0, 0, 0, 1, 1);
        step();
        chk_all("opm resume", 1, 0, 0, 1, 1);
        opm_i = 1'b0;

        // One-cycle reset mid-count with uif_o set
        chk("rst pre uif", 32'(uif_o), 32'd1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk_all("rst mid", 0, 0, 0, 0, 0);
        step();
        chk_all("rst rel", 0, 0, 0, 0, 1);
        step();
        chk_all("rst cnt1", 1, 0, 0, 0, 1);
        step();
        chk_all("rst wrap", 0, 0, 1, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
